perlane_scrambler: RTL and testbench

Transmit-side per-lane scrambler for the 25G PCS datapath. It is the inverse of the per-lane descrambler.
- Takes 256-bit encoded blocks from the upper layer.
- Scrambles them as four independent 64-bit slices using the self-synchronous polynomial G(x)=1+x^39+x^58.
- Registers the result toward the lower layer.
- Keeps saturating word and error statistics.
- Passes the idle indication from lower to upper.

---
 rtl/perlane_scrambler.sv | 116 +++++++++++
 tb/tb_perlane_scrambler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/perlane_scrambler.sv
// Transmit-side per-lane scrambler: four independent 64-bit slices of G(x)=1+x^39+x^58,
// registered toward the lower layer, with saturating word/error statistics.
module perlane_scrambler #(
  parameter logic [57:0] SEED       = 58'h3FF_FFFF_FFFF_FFFF,
  parameter bit          SCR_BYPASS = 1'b0,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_enable,
  input  logic [255:0]     in_txdata,
  input  logic             in_txdata_valid,
  input  logic             in_txdata_error,
  output logic             out_idle,
  output logic [255:0]     out_txdata,
  output logic             out_txdata_valid,
  output logic             out_txdata_error,
  input  logic             in_idle,
  input  logic             in_cnt_clear,
  output logic [CNT_W-1:0] out_word_cnt,
  output logic [CNT_W-1:0] out_err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0][57:0] state_r;
  logic [3:0][57:0] state_next_s;
  logic [255:0]     scr_s;
  logic [255:0]     data_next_s;
  logic [255:0]     txdata_r;
  logic             txvalid_r;
  logic             txerr_r;
  logic [CNT_W-1:0] word_cnt_r;
  logic [CNT_W-1:0] err_cnt_r;
  logic             acc_s;

  // Unrolled slice: e[57:0] is the previous 58 scrambled bits (oldest at 0), e[58+i] = s[i].
  function automatic logic [63:0] scramble64(input logic [57:0] st, input logic [63:0] d);
    logic [121:0] e;
    e = {64'd0, st};
    for (int i = 0; i < 64; i++) begin
      e[58+i] = d[i] ^ e[i+19] ^ e[i];
    end
    return e[121:58];
  endfunction

  assign acc_s    = in_enable & in_txdata_valid;
  assign out_idle = in_idle;

  // Scramble all slices and select the word and next state (frozen at SEED in bypass)
  always_comb begin
    scr_s        = 256'd0;
    data_next_s  = 256'd0;
    state_next_s = state_r;
    for (int k = 0; k < 4; k++) begin
      scr_s[64*k +: 64] = scramble64(state_r[k], in_txdata[64*k +: 64]);
    end
    if (SCR_BYPASS) begin
      data_next_s  = in_txdata;
      state_next_s = {4{SEED}};
    end else begin
      data_next_s = scr_s;
      for (int k = 0; k < 4; k++) begin
        state_next_s[k] = scr_s[64*k+6 +: 58];
      end
    end
  end

  // Output register and slice-state update on accepted words
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= {4{SEED}};
      txdata_r  <= 256'd0;
      txvalid_r <= 1'b0;
      txerr_r   <= 1'b0;
    end else if (acc_s) begin
      state_r   <= state_next_s;
      txdata_r  <= data_next_s;
      txvalid_r <= 1'b1;
      txerr_r   <= in_txdata_error;
    end else begin
      txvalid_r <= 1'b0;
      txerr_r   <= 1'b0;
    end
  end

  // Saturating statistics; a clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      word_cnt_r <= {CNT_W{1'b0}};
      err_cnt_r  <= {CNT_W{1'b0}};
    end else if (in_cnt_clear) begin
      word_cnt_r <= {CNT_W{1'b0}};
      err_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      if (acc_s && (word_cnt_r != CNT_MAX)) begin
        word_cnt_r <= word_cnt_r + CNT_ONE;
      end else begin
        word_cnt_r <= word_cnt_r;
      end
      if (acc_s && in_txdata_error && (err_cnt_r != CNT_MAX)) begin
        err_cnt_r <= err_cnt_r + CNT_ONE;
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end
  end

  assign out_txdata       = txdata_r;
  assign out_txdata_valid = txvalid_r;
  assign out_txdata_error = txerr_r;
  assign out_word_cnt     = word_cnt_r;
  assign out_err_cnt      = err_cnt_r;

endmodule

// File: tb/tb_perlane_scrambler.sv
// Self-checking bench: bit-stream reference scrambler/descrambler model, vector table,
// and directed sequences for enable gating, errors, saturation and bypass.
module tb_perlane_scrambler;

  localparam logic [57:0]  SEED = 58'h3FF_FFFF_FFFF_FFFF;
  localparam logic [255:0] C4   = {4{64'h03FF_FF80_0000_0000}};
  localparam logic [255:0] ONES = {256{1'b1}};
  localparam logic [255:0] BYPW = {4{64'h0123_4567_89AB_CDEF}};

  logic clk = 1'b0;
  logic reset_n;
  logic in_enable, in_txdata_valid, in_txdata_error, in_idle, in_cnt_clear;
  logic [255:0] in_txdata;

  logic m_idle, m_valid, m_err;  logic [255:0] m_data;  logic [31:0] m_wcnt, m_ecnt;
  logic s_idle, s_valid, s_err;  logic [255:0] s_data;  logic [3:0]  s_wcnt, s_ecnt;
  logic b_idle, b_valid, b_err;  logic [255:0] b_data;  logic [31:0] b_wcnt, b_ecnt;

  perlane_scrambler u_main (
    .clk(clk), .reset_n(reset_n), .in_enable(in_enable), .in_txdata(in_txdata),
    .in_txdata_valid(in_txdata_valid), .in_txdata_error(in_txdata_error), .out_idle(m_idle),
    .out_txdata(m_data), .out_txdata_valid(m_valid), .out_txdata_error(m_err), .in_idle(in_idle),
    .in_cnt_clear(in_cnt_clear), .out_word_cnt(m_wcnt), .out_err_cnt(m_ecnt));

  perlane_scrambler #(.CNT_W(4)) u_sat (
    .clk(clk), .reset_n(reset_n), .in_enable(in_enable), .in_txdata(in_txdata),
    .in_txdata_valid(in_txdata_valid), .in_txdata_error(in_txdata_error), .out_idle(s_idle),
    .out_txdata(s_data), .out_txdata_valid(s_valid), .out_txdata_error(s_err), .in_idle(in_idle),
    .in_cnt_clear(in_cnt_clear), .out_word_cnt(s_wcnt), .out_err_cnt(s_ecnt));

  perlane_scrambler #(.SCR_BYPASS(1'b1)) u_byp (
    .clk(clk), .reset_n(reset_n), .in_enable(in_enable), .in_txdata(in_txdata),
    .in_txdata_valid(in_txdata_valid), .in_txdata_error(in_txdata_error), .out_idle(b_idle),
    .out_txdata(b_data), .out_txdata_valid(b_valid), .out_txdata_error(b_err), .in_idle(in_idle),
    .in_cnt_clear(in_cnt_clear), .out_word_cnt(b_wcnt), .out_err_cnt(b_ecnt));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-slice bit streams, oldest first; only the last 58 bits are kept.
  bit tx_hist[4][$];
  bit rx_hist[4][$];
  logic [255:0] exp_data, exp_byp;
  logic exp_valid, exp_err;
  longint exp_wcnt, exp_ecnt, exp_swcnt, exp_secnt;
  bit rt_active;
  int rt_words, rt_match;
  logic [255:0] rt_sent[$];

  typedef struct {
    logic en; logic v; logic err; logic clr; logic [255:0] d;
    logic exp_v; logic exp_e; logic [255:0] exp_d; logic [31:0] exp_w; logic [31:0] exp_ec;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom;
    return r;
  endfunction

  function automatic longint sat_inc(input longint c, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (c >= mx) ? mx : c + 1;
  endfunction

  function automatic logic [255:0] ref_scramble(input logic [255:0] d);
    logic [255:0] r;
    int n;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 64; i++) begin
        n = tx_hist[k].size();
        r[64*k+i] = d[64*k+i] ^ tx_hist[k][n-39] ^ tx_hist[k][n-58];
        tx_hist[k].push_back(r[64*k+i]);
        void'(tx_hist[k].pop_front());
      end
    end
    return r;
  endfunction

  function automatic logic [255:0] ref_descramble(input logic [255:0] s);
    logic [255:0] d;
    int n;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 64; i++) begin
        n = rx_hist[k].size();
        d[64*k+i] = s[64*k+i] ^ rx_hist[k][n-39] ^ rx_hist[k][n-58];
        rx_hist[k].push_back(s[64*k+i]);
        void'(rx_hist[k].pop_front());
      end
    end
    return d;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; in_enable = 1'b0; in_txdata_valid = 1'b0; in_txdata_error = 1'b0;
    in_cnt_clear = 1'b0; in_txdata = 256'd0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      tx_hist[k].delete();
      for (int j = 0; j < 58; j++) tx_hist[k].push_back(SEED[j]);
    end
    exp_data = 256'd0; exp_byp = 256'd0; exp_valid = 1'b0; exp_err = 1'b0;
    exp_wcnt = 0; exp_ecnt = 0; exp_swcnt = 0; exp_secnt = 0;
    check("rst_data", m_data, 256'd0);
    check("rst_valid", 256'(m_valid), 256'd0);
    check("rst_err", 256'(m_err), 256'd0);
    check("rst_wcnt", 256'(m_wcnt), 256'd0);
    check("rst_ecnt", 256'(m_ecnt), 256'd0);
    check("rst_byp_data", b_data, 256'd0);
    reset_n = 1'b1;
  endtask

  task automatic step(input logic en, input logic v, input logic err, input logic clr,
                      input logic [255:0] d);
    logic acc;
    logic [255:0] rec, sent;
    in_enable = en; in_txdata_valid = v; in_txdata_error = err; in_cnt_clear = clr; in_txdata = d;
    @(posedge clk);
    acc = en & v;
    if (acc) begin
      exp_data = ref_scramble(d);
      exp_byp  = d;
      if (rt_active) rt_sent.push_back(d);
    end
    exp_valid = acc;
    exp_err   = acc & err;
    if (clr) begin
      exp_wcnt = 0; exp_ecnt = 0; exp_swcnt = 0; exp_secnt = 0;
    end else if (acc) begin
      exp_wcnt  = sat_inc(exp_wcnt, 32);
      exp_swcnt = sat_inc(exp_swcnt, 4);
      if (err) begin
        exp_ecnt  = sat_inc(exp_ecnt, 32);
        exp_secnt = sat_inc(exp_secnt, 4);
      end
    end
    #1;
    check("data", m_data, exp_data);
    check("valid", 256'(m_valid), 256'(exp_valid));
    check("err", 256'(m_err), 256'(exp_err));
    check("wcnt", 256'(m_wcnt), 256'(exp_wcnt));
    check("ecnt", 256'(m_ecnt), 256'(exp_ecnt));
    check("sat_wcnt", 256'(s_wcnt), 256'(exp_swcnt));
    check("sat_ecnt", 256'(s_ecnt), 256'(exp_secnt));
    check("byp_data", b_data, exp_byp);
    if (rt_active && m_valid) begin
      rec  = ref_descramble(m_data);
      sent = rt_sent.pop_front();
      if (rt_words > 0) begin
        check("roundtrip", rec, sent);
        if (rec === sent) rt_match++;
      end
      rt_words++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 256'd0, 1'b1, 1'b0, C4, 32'd1, 32'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, ONES,   1'b0, 1'b0, C4, 32'd1, 32'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, ONES,   1'b0, 1'b0, C4, 32'd1, 32'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, ONES,   1'b0, 1'b0, C4, 32'd0, 32'd0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 256'd0, 1'b0, 1'b0, C4, 32'd0, 32'd0};
    in_idle = 1'b0; rt_active = 1'b0; rt_words = 0; rt_match = 0;

    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(tbl[i].en, tbl[i].v, tbl[i].err, tbl[i].clr, tbl[i].d);
      check("tbl_data", m_data, tbl[i].exp_d);
      check("tbl_valid", 256'(m_valid), 256'(tbl[i].exp_v));
      check("tbl_err", 256'(m_err), 256'(tbl[i].exp_e));
      check("tbl_wcnt", 256'(m_wcnt), 256'(tbl[i].exp_w));
      check("tbl_ecnt", 256'(m_ecnt), 256'(tbl[i].exp_ec));
    end

    // Back-to-back burst through the reference descrambler with an arbitrary start state
    do_reset();
    for (int k = 0; k < 4; k++) begin
      rx_hist[k].delete();
      for (int j = 0; j < 58; j++) rx_hist[k].push_back(1'($urandom));
    end
    rt_sent.delete();
    rt_active = 1'b1;
    for (int i = 0; i < 1000; i++) step(1'b1, 1'b1, 1'b0, 1'b0, rand256());
    rt_active = 1'b0;
    check("rt_words", 256'(rt_words), 256'd1000);
    check("rt_match", 256'(rt_match), 256'd999);
    check("burst_wcnt", 256'(m_wcnt), 256'd1000);

    // Enable low overrides valid
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'($urandom), 1'b0, rand256());
    check("en_low_wcnt", 256'(m_wcnt), 256'd1000);
    check("en_low_valid", 256'(m_valid), 256'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, rand256());
    check("resume_wcnt", 256'(m_wcnt), 256'd1005);

    // Error on word 3 of 6
    step(1'b0, 1'b0, 1'b0, 1'b1, 256'd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, (i == 2) ? 1'b1 : 1'b0, 1'b0, rand256());
      check("err_word", 256'(m_err), (i == 2) ? 256'd1 : 256'd0);
    end
    check("err_cnt", 256'(m_ecnt), 256'd1);
    check("err_wcnt", 256'(m_wcnt), 256'd6);

    // Saturation of the 4-bit counter, then clear coincident with a valid word
    step(1'b0, 1'b0, 1'b0, 1'b1, 256'd0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'($urandom), 1'b0, rand256());
    check("sat_15", 256'(s_wcnt), 256'd15);
    check("main_20", 256'(m_wcnt), 256'd20);
    step(1'b1, 1'b1, 1'b1, 1'b1, rand256());
    check("sat_clr", 256'(s_wcnt), 256'd0);
    check("main_clr", 256'(m_wcnt), 256'd0);
    check("clr_ecnt", 256'(m_ecnt), 256'd0);

    // Bypass passes the word unchanged; idle is combinational
    step(1'b1, 1'b1, 1'b0, 1'b0, BYPW);
    check("byp_word", b_data, BYPW);
    check("byp_valid", 256'(b_valid), 256'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 256'd0);
    in_idle = 1'b1; #1;
    check("idle_hi", 256'(m_idle), 256'd1);
    check("idle_hi_byp", 256'(b_idle), 256'd1);
    in_idle = 1'b0; #1;
    check("idle_lo", 256'(m_idle), 256'd0);
    check("idle_lo_byp", 256'(b_idle), 256'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
